// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types for the multicycle CPU controller: FSM states, opcode map,
// ALU operation codes and the packed control word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH1 = 4'd0,
    S_FETCH2 = 4'd1,
    S_DECODE = 4'd2,
    S_ALU_EX = 4'd3,
    S_ALU_WB = 4'd4,
    S_LOAD   = 4'd5,
    S_STORE  = 4'd6,
    S_JUMP   = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // Opcodes 0xC..0xF are undefined and intentionally absent.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_JMP  = 4'h9,
    OP_BEQZ = 4'hA,
    OP_HALT = 4'hB
  } opcode_t;

  typedef logic [2:0] aluop_t;

  localparam aluop_t ALU_ADD   = 3'b000;
  localparam aluop_t ALU_SUB   = 3'b001;
  localparam aluop_t ALU_AND   = 3'b010;
  localparam aluop_t ALU_OR    = 3'b011;
  localparam aluop_t ALU_XOR   = 3'b100;
  localparam aluop_t ALU_INC   = 3'b101;
  localparam aluop_t ALU_PASSB = 3'b110;
  localparam aluop_t ALU_PASSA = 3'b111;

  typedef struct packed {
    logic   pcSelect;
    logic   pcEnable;
    logic   adrSelect;
    logic   ir1En;
    logic   ir2En;
    logic   op1Sel;
    logic   op2Sel;
    aluop_t aluControl;
    logic   regWrite;
    logic   wbSel;
    logic   memEnable;
    logic   halted;
  } ctrl_word_t;

  // ALU function for the register/immediate arithmetic group; ADDI shares ADD.
  function automatic aluop_t alu_for_opcode(input logic [3:0] op);
    aluop_t a;
    a = ALU_ADD;
    case (op)
      OP_SUB:  a = ALU_SUB;
      OP_AND:  a = ALU_AND;
      OP_OR:   a = ALU_OR;
      OP_XOR:  a = ALU_XOR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the controller and the datapath: opcode/zero in, control
// enables/selects and status out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if;
  logic [3:0]  opcode;
  logic        zero;
  logic        pcSelect;
  logic        pcEnable;
  logic        adrSelect;
  logic        ir1En;
  logic        ir2En;
  logic        op1Sel;
  logic        op2Sel;
  logic [2:0]  aluControl;
  logic        regWrite;
  logic        wbSel;
  logic        memEnable;
  logic        halted;
  logic        illegal;
  logic [15:0] instret;

  // Controller side
  modport master (
    input  opcode, zero,
    output pcSelect, pcEnable, adrSelect, ir1En, ir2En, op1Sel, op2Sel,
           aluControl, regWrite, wbSel, memEnable, halted, illegal, instret
  );

  // Datapath side
  modport slave (
    output opcode, zero,
    input  pcSelect, pcEnable, adrSelect, ir1En, ir2En, op1Sel, op2Sel,
           aluControl, regWrite, wbSel, memEnable, halted, illegal, instret
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_outputs.sv
//------------------------------------------------------------------------------
// ctrl_outputs
// Purely combinational Moore decoder: state (+ opcode, zero) -> control word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_outputs
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zero,
  output ctrl_word_t cw
);

  // Decode one control word per state; everything unlisted stays 0 / ADD.
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH1: begin
        cw.ir1En      = 1'b1;
        cw.aluControl = ALU_INC;
        cw.pcEnable   = 1'b1;
      end
      S_FETCH2: begin
        cw.ir2En      = 1'b1;
        cw.aluControl = ALU_INC;
        cw.pcEnable   = 1'b1;
      end
      S_ALU_EX: begin
        cw.op1Sel     = 1'b1;
        cw.op2Sel     = (opcode != OP_ADDI);
        cw.aluControl = alu_for_opcode(opcode);
      end
      S_ALU_WB: begin
        // ALU code held so aluoutM path stays consistent during write-back.
        cw.regWrite   = 1'b1;
        cw.aluControl = alu_for_opcode(opcode);
      end
      S_LOAD: begin
        cw.adrSelect  = 1'b1;
        cw.regWrite   = 1'b1;
        cw.wbSel      = 1'b1;
      end
      S_STORE: begin
        cw.adrSelect  = 1'b1;
        cw.memEnable  = 1'b1;
      end
      S_JUMP: begin
        cw.pcSelect   = 1'b1;
        cw.pcEnable   = 1'b1;
      end
      S_BRANCH: begin
        cw.op1Sel     = 1'b1;
        cw.aluControl = ALU_PASSA;
        cw.pcSelect   = 1'b1;
        cw.pcEnable   = zero;
      end
      S_HALT: begin
        cw.halted     = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// multicycle_ctrl
// Moore sequencer for the 8-bit multicycle datapath: fetch, decode, execute,
// write-back. Keeps retired-instruction count and sticky illegal flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_ctrl_if.master       bus
);

  state_t      state_q, state_d;
  logic [15:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  ctrl_word_t  cw_dec;
  ctrl_word_t  cw_out;

  // State, counter and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH1;
      instret_q <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_XOR, OP_ADDI: state_d = S_ALU_EX;
          OP_LD:                  state_d = S_LOAD;
          OP_ST:                  state_d = S_STORE;
          OP_JMP:                 state_d = S_JUMP;
          OP_BEQZ:                state_d = S_BRANCH;
          OP_HALT:                state_d = S_HALT;
          default:                state_d = S_FETCH1;  // NOP and undefined
        endcase
      end
      S_ALU_EX: state_d = S_ALU_WB;
      S_ALU_WB,
      S_LOAD,
      S_STORE,
      S_JUMP,
      S_BRANCH: state_d = S_FETCH1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH1;
    endcase
  end

  // Retire on every return to FETCH1 after decode, and once on entering HALT;
  // the illegal flag latches when an undefined opcode leaves DECODE.
  always_comb begin
    instret_d = instret_q;
    illegal_d = illegal_q;
    if (state_q == S_DECODE && state_d == S_HALT) begin
      instret_d = instret_q + 16'd1;
    end else if (state_d == S_FETCH1 && state_q != S_FETCH1 &&
                 state_q != S_FETCH2 && state_q != S_HALT) begin
      instret_d = instret_q + 16'd1;
    end
    if (state_q == S_DECODE && bus.opcode >= 4'hC) begin
      illegal_d = 1'b1;
    end
  end

  ctrl_outputs u_ctrl_outputs (
    .state  (state_q),
    .opcode (bus.opcode),
    .zero   (bus.zero),
    .cw     (cw_dec)
  );

  // While reset is held every enable, select and status bit reads 0.
  always_comb begin
    cw_out = cw_dec;
    if (!reset) begin
      cw_out = '0;
    end
  end

  assign bus.pcSelect   = cw_out.pcSelect;
  assign bus.pcEnable   = cw_out.pcEnable;
  assign bus.adrSelect  = cw_out.adrSelect;
  assign bus.ir1En      = cw_out.ir1En;
  assign bus.ir2En      = cw_out.ir2En;
  assign bus.op1Sel     = cw_out.op1Sel;
  assign bus.op2Sel     = cw_out.op2Sel;
  assign bus.aluControl = cw_out.aluControl;
  assign bus.regWrite   = cw_out.regWrite;
  assign bus.wbSel      = cw_out.wbSel;
  assign bus.memEnable  = cw_out.memEnable;
  assign bus.halted     = cw_out.halted;
  assign bus.illegal    = illegal_q;
  assign bus.instret    = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed self-checking bench: drives opcode/zero per instruction and compares
// the full control word each cycle against hand-computed values.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [15:0] exp_instret;
  logic        exp_illegal;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word order: {pcSelect,pcEnable,adrSelect,ir1En,ir2En,op1Sel,op2Sel,
  //              aluControl[2:0],regWrite,wbSel,memEnable,halted}
  localparam logic [13:0] W_F1    = {7'b0101000, 3'b101, 4'b0000};
  localparam logic [13:0] W_F2    = {7'b0100100, 3'b101, 4'b0000};
  localparam logic [13:0] W_DEC   = 14'h0000;
  localparam logic [13:0] W_ADDI  = {7'b0000010, 3'b000, 4'b0000};
  localparam logic [13:0] W_LOAD  = {7'b0010000, 3'b000, 4'b1100};
  localparam logic [13:0] W_STORE = {7'b0010000, 3'b000, 4'b0010};
  localparam logic [13:0] W_JUMP  = {7'b1100000, 3'b000, 4'b0000};
  localparam logic [13:0] W_BR_T  = {7'b1100010, 3'b111, 4'b0000};
  localparam logic [13:0] W_BR_N  = {7'b1000010, 3'b111, 4'b0000};
  localparam logic [13:0] W_HALT  = {7'b0000000, 3'b000, 4'b0001};

  function automatic logic [13:0] w_ex(input logic [2:0] a);
    return {7'b0000011, a, 4'b0000};
  endfunction

  function automatic logic [13:0] w_wb(input logic [2:0] a);
    return {7'b0000000, a, 4'b1000};
  endfunction

  function automatic logic [13:0] obs_word();
    return {bus.pcSelect, bus.pcEnable, bus.adrSelect, bus.ir1En, bus.ir2En,
            bus.op1Sel, bus.op2Sel, bus.aluControl, bus.regWrite, bus.wbSel,
            bus.memEnable, bus.halted};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the controller in FETCH1; returns at the next
  // FETCH1 negedge. Cycles 4/5 are checked only when the instruction has them.
  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic z, input int n,
                           input logic [13:0] w4, input logic [13:0] w5);
    bus.opcode = op;
    bus.zero   = z;
    #1;
    check_val({tag, "_instret"}, {16'h0, bus.instret}, {16'h0, exp_instret});
    check_val({tag, "_illegal"}, {31'h0, bus.illegal}, {31'h0, exp_illegal});
    check_val({tag, "_c1"}, {18'h0, obs_word()}, {18'h0, W_F1});
    @(negedge clk); #1;
    check_val({tag, "_c2"}, {18'h0, obs_word()}, {18'h0, W_F2});
    @(negedge clk); #1;
    check_val({tag, "_c3"}, {18'h0, obs_word()}, {18'h0, W_DEC});
    if (n >= 4) begin
      @(negedge clk); #1;
      check_val({tag, "_c4"}, {18'h0, obs_word()}, {18'h0, w4});
    end
    if (n >= 5) begin
      @(negedge clk); #1;
      check_val({tag, "_c5"}, {18'h0, obs_word()}, {18'h0, w5});
    end
    @(negedge clk);
    exp_instret = exp_instret + 16'd1;
    if (op >= 4'hC) exp_illegal = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_instret = 16'h0000;
    exp_illegal = 1'b0;
    reset       = 1'b0;
    bus.opcode  = 4'h1;
    bus.zero    = 1'b1;

    // Reset state
    #1;
    check_val("rst_word",    {18'h0, obs_word()},   32'h0);
    check_val("rst_instret", {16'h0, bus.instret},  32'h0);
    check_val("rst_illegal", {31'h0, bus.illegal},  32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Arithmetic group, ADDI, memory, control flow
    run_instr("add",  4'h1, 1'b0, 5, w_ex(3'b000), w_wb(3'b000));
    run_instr("addi", 4'h6, 1'b0, 5, W_ADDI,        w_wb(3'b000));
    run_instr("sub",  4'h2, 1'b0, 5, w_ex(3'b001), w_wb(3'b001));
    run_instr("and",  4'h3, 1'b0, 5, w_ex(3'b010), w_wb(3'b010));
    run_instr("or",   4'h4, 1'b0, 5, w_ex(3'b011), w_wb(3'b011));
    run_instr("xor",  4'h5, 1'b0, 5, w_ex(3'b100), w_wb(3'b100));
    run_instr("ld",   4'h7, 1'b0, 4, W_LOAD,  14'h0);
    run_instr("st",   4'h8, 1'b0, 4, W_STORE, 14'h0);
    run_instr("jmp",  4'h9, 1'b0, 4, W_JUMP,  14'h0);
    run_instr("beqt", 4'hA, 1'b1, 4, W_BR_T,  14'h0);
    run_instr("beqn", 4'hA, 1'b0, 4, W_BR_N,  14'h0);
    run_instr("nop",  4'h0, 1'b0, 3, 14'h0,   14'h0);
    run_instr("ilc",  4'hC, 1'b0, 3, 14'h0,   14'h0);
    run_instr("nop2", 4'h0, 1'b0, 3, 14'h0,   14'h0);

    // Counter wrap: hold 0xFFFF through the FETCH1 edge, then retire a NOP
    bus.opcode = 4'h0;
    force dut.instret_q = 16'hFFFF;
    #1;
    check_val("wrap_pre", {16'h0, bus.instret}, 32'h0000FFFF);
    @(negedge clk);
    release dut.instret_q;
    #1;
    check_val("wrap_hold", {16'h0, bus.instret}, 32'h0000FFFF);
    @(negedge clk);
    @(negedge clk);
    exp_instret = 16'h0000;
    run_instr("postwrap", 4'h0, 1'b0, 3, 14'h0, 14'h0);

    // Reset pulsed low while in ALU_EX
    bus.opcode = 4'h1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("pre_rst_ex", {18'h0, obs_word()}, {18'h0, w_ex(3'b000)});
    reset = 1'b0;
    #1;
    check_val("midrst_word",    {18'h0, obs_word()},  32'h0);
    check_val("midrst_instret", {16'h0, bus.instret}, 32'h0);
    check_val("midrst_illegal", {31'h0, bus.illegal}, 32'h0);
    @(negedge clk); #1;
    check_val("midrst_hold", {18'h0, obs_word()}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_instret = 16'h0000;
    exp_illegal = 1'b0;

    // Undefined opcode 0xE then HALT
    run_instr("ile", 4'hE, 1'b0, 3, 14'h0, 14'h0);
    bus.opcode = 4'hB;
    #1;
    check_val("halt_instret0", {16'h0, bus.instret}, 32'h1);
    check_val("halt_illegal0", {31'h0, bus.illegal}, 32'h1);
    check_val("halt_c1", {18'h0, obs_word()}, {18'h0, W_F1});
    @(negedge clk); #1;
    check_val("halt_c2", {18'h0, obs_word()}, {18'h0, W_F2});
    @(negedge clk); #1;
    check_val("halt_c3", {18'h0, obs_word()}, {18'h0, W_DEC});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_val("halt_word",    {18'h0, obs_word()},  {18'h0, W_HALT});
      check_val("halt_instret", {16'h0, bus.instret}, 32'h2);
      check_val("halt_illegal", {31'h0, bus.illegal}, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
